// File: rtl/range_counter_pkg.sv
// Shared types for the programmable bounded counter.
// Holds the counting-mode and phase enums plus the mode encodings seen on mode_in.
// No logic lives here apart from a small cast helper.
package range_counter_pkg;

  localparam logic [1:0] MODE_UP_ENC       = 2'd0;
  localparam logic [1:0] MODE_DOWN_ENC     = 2'd1;
  localparam logic [1:0] MODE_PINGPONG_ENC = 2'd2;
  localparam logic [1:0] MODE_ONESHOT_ENC  = 2'd3;

  typedef enum logic [1:0] {
    UP       = MODE_UP_ENC,
    DOWN     = MODE_DOWN_ENC,
    PINGPONG = MODE_PINGPONG_ENC,
    ONESHOT  = MODE_ONESHOT_ENC
  } mode_e;

  // FIN is only ever reached in ONESHOT, once the upper bound has been hit.
  typedef enum logic {
    RUN = 1'b0,
    FIN = 1'b1
  } phase_e;

  function automatic mode_e to_mode(input logic [1:0] m);
    return mode_e'(m);
  endfunction

endpackage

// File: rtl/range_next.sv
// Next-count computation for one enabled step of the bounded counter.
// Combinational, zero latency; no handshake, the caller decides when to apply it.
// Ports: count/lo/hi/mode/dir in; next_out, next_dir, hit_bound (bound reached this step) out.
module range_next
  import range_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  mode_e            mode,
  input  logic             dir,
  output logic [WIDTH-1:0] next_out,
  output logic             next_dir,
  output logic             hit_bound
);

  logic at_hi;
  logic at_lo;
  logic span;

  // Bounds are detected by equality only, so the full 0..2^WIDTH-1 range
  // never relies on the adder rolling over.
  assign at_hi = (count == hi);
  assign at_lo = (count == lo);
  assign span  = (hi != lo);

  always_comb begin
    next_out  = count;
    next_dir  = dir;
    hit_bound = 1'b0;
    unique case (mode)
      UP: begin
        next_dir = 1'b1;
        if (at_hi) begin
          next_out  = lo;
          hit_bound = 1'b1;
        end else begin
          next_out = count + WIDTH'(1);
        end
      end
      DOWN: begin
        next_dir = 1'b0;
        if (at_lo) begin
          next_out  = hi;
          hit_bound = 1'b1;
        end else begin
          next_out = count - WIDTH'(1);
        end
      end
      PINGPONG: begin
        if (dir) begin
          if (at_hi) begin
            hit_bound = 1'b1;
            next_dir  = 1'b0;
            // With lo==hi there is nowhere to turn to, so the count holds.
            if (span) next_out = hi - WIDTH'(1);
          end else begin
            next_out = count + WIDTH'(1);
          end
        end else begin
          if (at_lo) begin
            hit_bound = 1'b1;
            next_dir  = 1'b1;
            if (span) next_out = lo + WIDTH'(1);
          end else begin
            next_out = count - WIDTH'(1);
          end
        end
      end
      ONESHOT: begin
        next_dir = 1'b1;
        if (at_hi) begin
          hit_bound = 1'b1;
        end else begin
          next_out = count + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/range_counter.sv
// Runtime-programmable bounded counter (up, down, ping-pong, one-shot) with wrap/done flags.
// One cycle latency: every output is registered and reflects the previous rising edge.
// No backpressure; priority per edge is rst_n > cfg_load > start > en.
// Ports: clk, rst_n (sync, active low), en, start, cfg_load, mode_in/lo_in/hi_in in;
//        out (count), wrap (bound pulse), done (one-shot finished), dir (1=up), cfg_err (rejected load) out.
module range_counter
  import range_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int RESET_LO = 2,
  parameter int RESET_HI = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             cfg_load,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] hi_in,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             done,
  output logic             dir,
  output logic             cfg_err
);

  if (WIDTH < 2) begin : g_bad_width
    $error("range_counter: WIDTH must be at least 2");
  end
  if (RESET_LO > RESET_HI) begin : g_bad_bounds
    $error("range_counter: RESET_LO must not exceed RESET_HI");
  end

  localparam logic [WIDTH-1:0] RST_LO = WIDTH'(RESET_LO);
  localparam logic [WIDTH-1:0] RST_HI = WIDTH'(RESET_HI);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  phase_e           phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             cfg_err_q, cfg_err_d;

  logic [WIDTH-1:0] step_out;
  logic             step_dir;
  logic             step_hit;

  range_next #(.WIDTH(WIDTH)) u_next (
    .count     (out_q),
    .lo        (lo_q),
    .hi        (hi_q),
    .mode      (mode_q),
    .dir       (dir_q),
    .next_out  (step_out),
    .next_dir  (step_dir),
    .hit_bound (step_hit)
  );

  always_comb begin
    out_d     = out_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    phase_d   = phase_q;
    wrap_d    = 1'b0;
    cfg_err_d = 1'b0;
    if (cfg_load) begin
      // A rejected load leaves every piece of state alone apart from the error pulse.
      if (lo_in <= hi_in) begin
        lo_d    = lo_in;
        hi_d    = hi_in;
        mode_d  = to_mode(mode_in);
        out_d   = (mode_d == DOWN) ? hi_in : lo_in;
        dir_d   = (mode_d != DOWN);
        phase_d = RUN;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (start) begin
      out_d   = (mode_q == DOWN) ? hi_q : lo_q;
      dir_d   = (mode_q != DOWN);
      phase_d = RUN;
    end else if (en && (phase_q == RUN)) begin
      out_d  = step_out;
      dir_d  = step_dir;
      wrap_d = step_hit;
      if ((mode_q == ONESHOT) && step_hit) phase_d = FIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= RST_LO;
      lo_q      <= RST_LO;
      hi_q      <= RST_HI;
      mode_q    <= UP;
      dir_q     <= 1'b1;
      phase_q   <= RUN;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out     = out_q;
  assign wrap    = wrap_q;
  assign done    = (phase_q == FIN);
  assign dir     = dir_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_range_counter.sv
module tb_range_counter;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         start;
  logic         cfg_load;
  logic [1:0]   mode_in;
  logic [W-1:0] lo_in;
  logic [W-1:0] hi_in;
  logic [W-1:0] out;
  logic         wrap;
  logic         done;
  logic         dir;
  logic         cfg_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: plain integers following the counting rules directly.
  int m_lo, m_hi, m_mode, m_out;
  bit m_dir, m_done, m_wrap, m_err;

  range_counter #(.WIDTH(W), .RESET_LO(2), .RESET_HI(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .cfg_load (cfg_load),
    .mode_in  (mode_in),
    .lo_in    (lo_in),
    .hi_in    (hi_in),
    .out      (out),
    .wrap     (wrap),
    .done     (done),
    .dir      (dir),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_lo = 2; m_hi = 4; m_mode = 0; m_out = 2;
    m_dir = 1'b1; m_done = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
  endtask

  // Mode numbers: 0 up, 1 down, 2 ping-pong, 3 one-shot.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_wrap = 1'b0;
      m_err  = 1'b0;
      if (cfg_load) begin
        if (int'(lo_in) <= int'(hi_in)) begin
          m_lo = lo_in; m_hi = hi_in; m_mode = mode_in;
          m_out = (m_mode == 1) ? m_hi : m_lo;
          m_dir = (m_mode != 1);
          m_done = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end else if (start) begin
        m_out = (m_mode == 1) ? m_hi : m_lo;
        m_dir = (m_mode != 1);
        m_done = 1'b0;
      end else if (en && !m_done) begin
        if (m_mode == 0) begin
          if (m_out == m_hi) begin m_out = m_lo; m_wrap = 1'b1; end
          else m_out = m_out + 1;
        end else if (m_mode == 1) begin
          if (m_out == m_lo) begin m_out = m_hi; m_wrap = 1'b1; end
          else m_out = m_out - 1;
        end else if (m_mode == 2) begin
          if (m_dir && m_out == m_hi) begin
            m_wrap = 1'b1; m_dir = 1'b0;
            if (m_hi > m_lo) m_out = m_hi - 1;
          end else if (!m_dir && m_out == m_lo) begin
            m_wrap = 1'b1; m_dir = 1'b1;
            if (m_hi > m_lo) m_out = m_lo + 1;
          end else begin
            m_out = m_dir ? m_out + 1 : m_out - 1;
          end
        end else begin
          if (m_out == m_hi) begin m_done = 1'b1; m_wrap = 1'b1; end
          else m_out = m_out + 1;
        end
      end
    end
  endtask

  function automatic logic [W+3:0] exp_vec();
    return {W'(m_out), m_wrap, m_done, m_dir, m_err};
  endfunction

  function automatic logic [W+3:0] obs_vec();
    return {out, wrap, done, dir, cfg_err};
  endfunction

  // Inputs change at the falling edge; the model advances at the rising edge;
  // outputs are inspected at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; en = 1'b0; start = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic load(input int mode, input int lo, input int hi);
    idle();
    cfg_load = 1'b1;
    mode_in = 2'(mode); lo_in = W'(lo); hi_in = W'(hi);
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0; en = 1'b1; mode_in = 2'd0; lo_in = '0; hi_in = '0;
    tick();
    tick();
    n_cmp++;
    if ({out, wrap, done, dir, cfg_err} !== {3'd2, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got out=%0d wrap=%b done=%b dir=%b err=%b, want out=2 wrap=0 done=0 dir=1 err=0",
               out, wrap, done, dir, cfg_err);
    end
  endtask

  task automatic test_up_default();
    int exp_out[5]  = '{3, 4, 2, 3, 4};
    bit exp_wrap[5] = '{0, 0, 1, 0, 0};
    idle();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({out, wrap, dir} !== {W'(exp_out[i]), exp_wrap[i], 1'b1}) begin
        n_fail++;
        $display("FAIL up_default step %0d: got out=%0d wrap=%b dir=%b, want out=%0d wrap=%b dir=1",
                 i, out, wrap, dir, exp_out[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_pingpong();
    int exp_out[5]  = '{2, 3, 2, 1, 2};
    bit exp_wrap[5] = '{0, 0, 1, 0, 1};
    bit exp_dir[5]  = '{1, 1, 0, 0, 1};
    load(2, 1, 3);
    n_cmp++;
    if ({out, dir} !== {3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL pingpong_load: got out=%0d dir=%b, want out=1 dir=1", out, dir);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({out, wrap, dir} !== {W'(exp_out[i]), exp_wrap[i], exp_dir[i]}) begin
        n_fail++;
        $display("FAIL pingpong step %0d: got out=%0d wrap=%b dir=%b, want out=%0d wrap=%b dir=%b",
                 i, out, wrap, dir, exp_out[i], exp_wrap[i], exp_dir[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_out[4]  = '{6, 7, 7, 7};
    bit exp_wrap[4] = '{0, 0, 1, 0};
    bit exp_done[4] = '{0, 0, 1, 1};
    load(3, 5, 7);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({out, wrap, done} !== {W'(exp_out[i]), exp_wrap[i], exp_done[i]}) begin
        n_fail++;
        $display("FAIL oneshot step %0d: got out=%0d wrap=%b done=%b, want out=%0d wrap=%b done=%b",
                 i, out, wrap, done, exp_out[i], exp_wrap[i], exp_done[i]);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({out, wrap, done} !== {3'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL oneshot_restart: got out=%0d wrap=%b done=%b, want out=5 wrap=0 done=0", out, wrap, done);
    end
  endtask

  task automatic test_cfg_err();
    int exp_out[4] = '{2, 2, 3, 1};
    bit exp_err[4] = '{0, 1, 0, 0};
    load(0, 1, 3);
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      cfg_load = (i == 1);
      mode_in = 2'd1; lo_in = 3'd6; hi_in = 3'd2;
      tick();
      n_cmp++;
      if ({out, cfg_err} !== {W'(exp_out[i]), exp_err[i]}) begin
        n_fail++;
        $display("FAIL cfg_err step %0d: got out=%0d cfg_err=%b, want out=%0d cfg_err=%b",
                 i, out, cfg_err, exp_out[i], exp_err[i]);
      end
    end
    idle();
  endtask

  task automatic test_full_down();
    idle();
    cfg_load = 1'b1; start = 1'b1; en = 1'b1;
    mode_in = 2'd1; lo_in = 3'd0; hi_in = 3'd7;
    tick();
    cfg_load = 1'b0; start = 1'b0;
    n_cmp++;
    if ({out, dir, wrap} !== {3'd7, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL full_down_load: got out=%0d dir=%b wrap=%b, want out=7 dir=0 wrap=0", out, dir, wrap);
    end
    for (int i = 0; i < 8; i++) begin
      int want;
      want = (i == 7) ? 7 : 6 - i;
      tick();
      n_cmp++;
      if ({out, wrap} !== {W'(want), (i == 7)}) begin
        n_fail++;
        $display("FAIL full_down step %0d: got out=%0d wrap=%b, want out=%0d wrap=%b",
                 i, out, wrap, want, (i == 7));
      end
    end
  endtask

  task automatic test_degenerate();
    load(3, 5, 5);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out, wrap, done} !== {3'd5, (i == 0), 1'b1}) begin
        n_fail++;
        $display("FAIL degenerate_oneshot step %0d: got out=%0d wrap=%b done=%b, want out=5 wrap=%b done=1",
                 i, out, wrap, done, (i == 0));
      end
    end
    load(0, 3, 3);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out, wrap} !== {3'd3, 1'b1}) begin
        n_fail++;
        $display("FAIL degenerate_up step %0d: got out=%0d wrap=%b, want out=3 wrap=1", i, out, wrap);
      end
    end
  endtask

  task automatic test_reset_mid_pingpong();
    load(2, 0, 5);
    en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0; cfg_load = 1'b1; start = 1'b1;
    mode_in = 2'd1; lo_in = 3'd0; hi_in = 3'd7;
    tick();
    idle();
    n_cmp++;
    if ({out, wrap, done, dir, cfg_err} !== {3'd2, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_pp: got out=%0d wrap=%b done=%b dir=%b err=%b, want out=2 wrap=0 done=0 dir=1 err=0",
               out, wrap, done, dir, cfg_err);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_pp_after step %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      cfg_load = ($urandom_range(0, 7) == 0);
      start    = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      mode_in  = 2'($urandom_range(0, 3));
      lo_in    = W'($urandom_range(0, 7));
      hi_in    = ($urandom_range(0, 3) == 0) ? lo_in : W'($urandom_range(0, 7));
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got {out,wrap,done,dir,err}=%b want %b", i, obs_vec(), exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_default();
    test_pingpong();
    test_oneshot();
    test_cfg_err();
    test_full_down();
    test_degenerate();
    test_reset_mid_pingpong();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
